// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential multiplier family.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SIGN,
        DONE
    } t_mult_state;

    // Number of radix-2^digit_bits steps needed to consume an in_bits multiplier.
    function automatic int digit_count(input int in_bits, input int digit_bits);
        return in_bits / digit_bits;
    endfunction

endpackage

// File: rtl/adder.sv
// Plain two-operand adder from the arithmetics library.
module adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/mult_pp_gen.sv
// Combinational partial product of an IN_BITS multiplicand and one DIGIT_BITS multiplier digit.
module mult_pp_gen #(
    parameter int IN_BITS    = 8,
    parameter int DIGIT_BITS = 1
) (
    input  logic [IN_BITS-1:0]            mcand,
    input  logic [DIGIT_BITS-1:0]         digit,
    output logic [IN_BITS+DIGIT_BITS-1:0] pp
);

    localparam int PP_BITS = IN_BITS + DIGIT_BITS;

    // Shift-and-add over the digit bits keeps the cell a pure AND/adder array.
    always_comb begin
        pp = '0;
        for (int i = 0; i < DIGIT_BITS; i++) begin
            if (digit[i]) begin
                pp = pp + (PP_BITS'(mcand) << i);
            end
        end
    end

endmodule

// File: rtl/mult_seq.sv
// Sequential shift-and-add multiplier, DIGIT_BITS multiplier bits per cycle,
// unsigned or two's-complement operands chosen per operation, with truncation overflow.
module mult_seq #(
    parameter int IN_BITS    = 8,
    parameter int OUT_BITS   = 16,
    parameter int DIGIT_BITS = 1
) (
    input  logic                in_clk,
    input  logic                in_rst,
    input  logic [IN_BITS-1:0]  in_a,
    input  logic [IN_BITS-1:0]  in_b,
    input  logic                in_signed,
    input  logic                in_start,
    output logic                out_ready,
    output logic                out_busy,
    output logic                out_finished,
    output logic [OUT_BITS-1:0] out_prod,
    output logic                out_ovf
);

    import mult_pkg::*;

    localparam int N        = digit_count(IN_BITS, DIGIT_BITS);
    localparam int ACC_BITS = 2 * IN_BITS;
    localparam int PP_BITS  = IN_BITS + DIGIT_BITS;
    localparam int CNT_BITS = (N > 1) ? $clog2(N) : 1;
    localparam int EXT_BITS = ((OUT_BITS > ACC_BITS) ? OUT_BITS : ACC_BITS) + 1;
    localparam int UP_BITS  = EXT_BITS - OUT_BITS;

    if (IN_BITS % DIGIT_BITS != 0) begin : g_bad_digit
        $error("mult_seq: DIGIT_BITS must divide IN_BITS");
    end

    t_mult_state           state;
    logic [IN_BITS-1:0]    mag_a;
    logic [IN_BITS-1:0]    b_sh;
    logic                  neg;
    logic                  sgn_q;
    logic [ACC_BITS-1:0]   acc;
    logic [CNT_BITS-1:0]   k;

    logic [IN_BITS-1:0]    abs_a;
    logic [IN_BITS-1:0]    abs_b;
    logic [PP_BITS-1:0]    pp;
    logic [ACC_BITS-1:0]   pp_shift;
    logic [ACC_BITS-1:0]   acc_next;
    logic [ACC_BITS-1:0]   res;
    logic [EXT_BITS-1:0]   ext_s;
    logic [EXT_BITS-1:0]   ext_u;
    logic [EXT_BITS-1:0]   ext;
    logic [OUT_BITS-1:0]   prod_next;
    logic                  ovf_next;

    // The most negative operand negates to itself, which is its correct unsigned magnitude.
    assign abs_a = (in_signed && in_a[IN_BITS-1]) ? -in_a : in_a;
    assign abs_b = (in_signed && in_b[IN_BITS-1]) ? -in_b : in_b;

    mult_pp_gen #(
        .IN_BITS    (IN_BITS),
        .DIGIT_BITS (DIGIT_BITS)
    ) u_pp_gen (
        .mcand (mag_a),
        .digit (b_sh[DIGIT_BITS-1:0]),
        .pp    (pp)
    );

    assign pp_shift = ACC_BITS'(pp) << (32'(k) * DIGIT_BITS);

    adder #(
        .WIDTH (ACC_BITS)
    ) u_adder (
        .a   (acc),
        .b   (pp_shift),
        .sum (acc_next)
    );

    // One extra bit above both widths lets a single compare cover truncation and extension.
    assign res       = neg ? -acc : acc;
    assign ext_s     = EXT_BITS'($signed(res));
    assign ext_u     = EXT_BITS'(res);
    assign ext       = sgn_q ? ext_s : ext_u;
    assign prod_next = ext[OUT_BITS-1:0];
    assign ovf_next  = ext[EXT_BITS-1:OUT_BITS] != {UP_BITS{sgn_q & ext[OUT_BITS-1]}};

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state        <= IDLE;
            mag_a        <= '0;
            b_sh         <= '0;
            neg          <= 1'b0;
            sgn_q        <= 1'b0;
            acc          <= '0;
            k            <= '0;
            out_ready    <= 1'b1;
            out_busy     <= 1'b0;
            out_finished <= 1'b0;
            out_prod     <= '0;
            out_ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (in_start) begin
                        state        <= RUN;
                        mag_a        <= abs_a;
                        b_sh         <= abs_b;
                        neg          <= in_signed & (in_a[IN_BITS-1] ^ in_b[IN_BITS-1]);
                        sgn_q        <= in_signed;
                        acc          <= '0;
                        k            <= '0;
                        out_ready    <= 1'b0;
                        out_busy     <= 1'b1;
                        out_finished <= 1'b0;
                    end
                end
                RUN: begin
                    acc  <= acc_next;
                    b_sh <= b_sh >> DIGIT_BITS;
                    k    <= k + CNT_BITS'(1);
                    if (k == CNT_BITS'(N - 1)) begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    acc          <= res;
                    out_prod     <= prod_next;
                    out_ovf      <= ovf_next;
                    out_ready    <= 1'b1;
                    out_busy     <= 1'b0;
                    out_finished <= 1'b1;
                    state        <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
